// File: rtl/axis_pkt_monitor.sv
// AXI-Stream passthrough with output+skid buffering and per-packet length/error monitoring.
// Produces a one-cycle completion report per packet plus cumulative packet/byte/error counters.
module axis_pkt_monitor #(
    parameter int MAX_PKT_BYTES = 9600
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] s_axis_tdata,
    input  logic [7:0]  s_axis_tkeep,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic [63:0] m_axis_tdata,
    output logic [7:0]  m_axis_tkeep,
    output logic        m_axis_tlast,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    input  logic        stat_clear,
    output logic [31:0] pkt_count,
    output logic [47:0] byte_count,
    output logic [15:0] err_count,
    output logic        pkt_done,
    output logic [15:0] pkt_len,
    output logic        pkt_err
);

    typedef enum logic {IDLE, BODY} state_t;

    localparam logic [31:0] MAX_BYTES = 32'(MAX_PKT_BYTES);

    // stream buffering
    logic        tready_q, tready_d;
    logic        out_valid_q, out_valid_d;
    logic [63:0] out_data_q, out_data_d;
    logic [7:0]  out_keep_q, out_keep_d;
    logic        out_last_q, out_last_d;
    logic        skid_valid_q, skid_valid_d;
    logic [63:0] skid_data_q, skid_data_d;
    logic [7:0]  skid_keep_q, skid_keep_d;
    logic        skid_last_q, skid_last_d;

    // packet monitor
    state_t      state_q, state_d;
    logic [15:0] len_q, len_d;
    logic        err_q, err_d;
    logic        pkt_done_q, pkt_done_d;
    logic [15:0] pkt_len_q, pkt_len_d;
    logic        pkt_err_q, pkt_err_d;
    logic [31:0] pkt_count_q, pkt_count_d;
    logic [47:0] byte_count_q, byte_count_d;
    logic [15:0] err_count_q, err_count_d;

    logic        in_hs;
    logic [3:0]  beat_bytes;
    logic [6:0]  keep_gap;
    logic        last_keep_ok;
    logic        beat_err;
    logic [15:0] len_base;
    logic        err_base;
    logic [16:0] len_sum;
    logic [15:0] len_sat;
    logic        err_sum;

    assign in_hs = s_axis_tvalid & tready_q;

    // A legal final-beat mask has no set bit sitting above a clear bit.
    generate
        for (genvar gi = 0; gi < 7; gi++) begin : g_keep_gap
            assign keep_gap[gi] = s_axis_tkeep[gi+1] & ~s_axis_tkeep[gi];
        end
    endgenerate

    assign last_keep_ok = s_axis_tkeep[0] & ~(|keep_gap);
    assign beat_err     = s_axis_tlast ? ~last_keep_ok : (s_axis_tkeep != 8'hFF);

    always_comb begin
        beat_bytes = 4'd0;
        for (int i = 0; i < 8; i++) begin
            beat_bytes = beat_bytes + {3'd0, s_axis_tkeep[i]};
        end
    end

    assign len_base = (state_q == BODY) ? len_q : 16'd0;
    assign err_base = (state_q == BODY) ? err_q : 1'b0;
    assign len_sum  = {1'b0, len_base} + {13'd0, beat_bytes};
    assign len_sat  = len_sum[16] ? 16'hFFFF : len_sum[15:0];
    assign err_sum  = err_base | beat_err | ({16'd0, len_sat} > MAX_BYTES);

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_keep_d   = out_keep_q;
        out_last_d   = out_last_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_keep_d  = skid_keep_q;
        skid_last_d  = skid_last_q;
        if (!out_valid_q || m_axis_tready) begin
            // Skid holds the older beat; while it is full no new beat is accepted.
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                out_keep_d   = skid_keep_q;
                out_last_d   = skid_last_q;
                skid_valid_d = 1'b0;
            end else if (in_hs) begin
                out_valid_d = 1'b1;
                out_data_d  = s_axis_tdata;
                out_keep_d  = s_axis_tkeep;
                out_last_d  = s_axis_tlast;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (in_hs) begin
            skid_valid_d = 1'b1;
            skid_data_d  = s_axis_tdata;
            skid_keep_d  = s_axis_tkeep;
            skid_last_d  = s_axis_tlast;
        end
        tready_d = ~skid_valid_d;
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        err_d      = err_q;
        pkt_done_d = 1'b0;
        pkt_len_d  = pkt_len_q;
        pkt_err_d  = pkt_err_q;
        if (in_hs) begin
            if (s_axis_tlast) begin
                state_d    = IDLE;
                len_d      = 16'd0;
                err_d      = 1'b0;
                pkt_done_d = 1'b1;
                pkt_len_d  = len_sat;
                pkt_err_d  = err_sum;
            end else begin
                state_d = BODY;
                len_d   = len_sat;
                err_d   = err_sum;
            end
        end
    end

    always_comb begin
        pkt_count_d  = pkt_count_q;
        byte_count_d = byte_count_q;
        err_count_d  = err_count_q;
        if (stat_clear) begin
            pkt_count_d  = 32'd0;
            byte_count_d = 48'd0;
            err_count_d  = 16'd0;
        end else if (pkt_done_d) begin
            pkt_count_d  = pkt_count_q + 32'd1;
            byte_count_d = byte_count_q + {32'd0, pkt_len_d};
            if (pkt_err_d && (err_count_q != 16'hFFFF)) begin
                err_count_d = err_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tready_q     <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= 64'd0;
            out_keep_q   <= 8'd0;
            out_last_q   <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= 64'd0;
            skid_keep_q  <= 8'd0;
            skid_last_q  <= 1'b0;
            state_q      <= IDLE;
            len_q        <= 16'd0;
            err_q        <= 1'b0;
            pkt_done_q   <= 1'b0;
            pkt_len_q    <= 16'd0;
            pkt_err_q    <= 1'b0;
            pkt_count_q  <= 32'd0;
            byte_count_q <= 48'd0;
            err_count_q  <= 16'd0;
        end else begin
            tready_q     <= tready_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_keep_q   <= out_keep_d;
            out_last_q   <= out_last_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_keep_q  <= skid_keep_d;
            skid_last_q  <= skid_last_d;
            state_q      <= state_d;
            len_q        <= len_d;
            err_q        <= err_d;
            pkt_done_q   <= pkt_done_d;
            pkt_len_q    <= pkt_len_d;
            pkt_err_q    <= pkt_err_d;
            pkt_count_q  <= pkt_count_d;
            byte_count_q <= byte_count_d;
            err_count_q  <= err_count_d;
        end
    end

    assign s_axis_tready = tready_q;
    assign m_axis_tvalid = out_valid_q;
    assign m_axis_tdata  = out_data_q;
    assign m_axis_tkeep  = out_keep_q;
    assign m_axis_tlast  = out_last_q;
    assign pkt_done      = pkt_done_q;
    assign pkt_len       = pkt_len_q;
    assign pkt_err       = pkt_err_q;
    assign pkt_count     = pkt_count_q;
    assign byte_count    = byte_count_q;
    assign err_count     = err_count_q;

endmodule

// File: tb/tb_axis_pkt_monitor.sv
// Directed bench for axis_pkt_monitor: passthrough, backpressure, error rules,
// length limit, statistics clear and reset abort, with hand-computed expectations.
module tb_axis_pkt_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] s_axis_tdata = '0;
    logic [7:0]  s_axis_tkeep = '0;
    logic        s_axis_tlast = 1'b0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic [63:0] m_axis_tdata;
    logic [7:0]  m_axis_tkeep;
    logic        m_axis_tlast;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic        stat_clear = 1'b0;
    logic [31:0] pkt_count;
    logic [47:0] byte_count;
    logic [15:0] err_count;
    logic        pkt_done;
    logic [15:0] pkt_len;
    logic        pkt_err;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    typedef struct {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
        int          c;
    } beat_t;

    typedef struct {
        logic [15:0] len;
        logic        err;
        int          c;
    } rep_t;

    beat_t out_q[$];
    rep_t  rep_q[$];
    int    in_cyc[$];

    axis_pkt_monitor #(.MAX_PKT_BYTES(64)) dut (
        .clk(clk),
        .rst(rst),
        .s_axis_tdata(s_axis_tdata),
        .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tlast(s_axis_tlast),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata),
        .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tlast(m_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .stat_clear(stat_clear),
        .pkt_count(pkt_count),
        .byte_count(byte_count),
        .err_count(err_count),
        .pkt_done(pkt_done),
        .pkt_len(pkt_len),
        .pkt_err(pkt_err)
    );

    always #5 clk = ~clk;

    // Capture handshakes and reports with the cycle number they were seen at.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst) begin
            if (s_axis_tvalid && s_axis_tready) in_cyc.push_back(cyc);
            if (m_axis_tvalid && m_axis_tready)
                out_q.push_back('{m_axis_tdata, m_axis_tkeep, m_axis_tlast, cyc});
            if (pkt_done) begin
                rep_q.push_back('{pkt_len, pkt_err, cyc});
                $display("[%0d] pkt_done len=%0d err=%0b", cyc, pkt_len, pkt_err);
            end
        end
    end

    task automatic clear_logs();
        out_q.delete();
        rep_q.delete();
        in_cyc.delete();
    endtask

    task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
        int n;
        n = 0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        @(negedge clk);
        while (!s_axis_tready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!s_axis_tready) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: s_axis_tready got 0 required 1 within 100 cycles");
        end
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic send_pkt(input int beats, input logic [7:0] last_keep);
        for (int i = 0; i < beats; i++) begin
            send_beat(64'hA000 + 64'(i), (i == beats - 1) ? last_keep : 8'hFF, i == beats - 1);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({s_axis_tready, m_axis_tvalid, m_axis_tlast, pkt_done, pkt_err} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got %b required 00000",
                     {s_axis_tready, m_axis_tvalid, m_axis_tlast, pkt_done, pkt_err});
        end
        vectors++;
        if ({m_axis_tdata, m_axis_tkeep, pkt_len} !== 88'd0) begin
            miscompares++;
            $display("FAIL reset_data: got %h/%h/%h required 0", m_axis_tdata, m_axis_tkeep, pkt_len);
        end
        vectors++;
        if ({pkt_count, byte_count, err_count} !== 96'd0) begin
            miscompares++;
            $display("FAIL reset_counters: got %0d/%0d/%0d required 0", pkt_count, byte_count, err_count);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if (s_axis_tready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release_tready: got %b required 1", s_axis_tready);
        end
    endtask

    task automatic test_basic();
        logic [63:0] dat [3];
        logic [7:0]  kp  [3];
        dat[0] = 64'h0011223344556677; kp[0] = 8'hFF;
        dat[1] = 64'h8899AABBCCDDEEFF; kp[1] = 8'hFF;
        dat[2] = 64'hDEADBEEFCAFEF00D; kp[2] = 8'h0F;
        clear_logs();
        m_axis_tready = 1'b1;
        for (int i = 0; i < 3; i++) send_beat(dat[i], kp[i], i == 2);
        repeat (4) @(posedge clk);
        #1;
        vectors++;
        if (out_q.size() != 3 || in_cyc.size() != 3) begin
            miscompares++;
            $display("FAIL basic_beats: got %0d out/%0d in required 3", out_q.size(), in_cyc.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                vectors++;
                if (out_q[i].d !== dat[i] || out_q[i].k !== kp[i] || out_q[i].l !== (i == 2)
                    || out_q[i].c != in_cyc[i] + 1) begin
                    miscompares++;
                    $display("FAIL basic_beat%0d: got %h/%h/%b @%0d required %h/%h/%b @%0d",
                             i, out_q[i].d, out_q[i].k, out_q[i].l, out_q[i].c,
                             dat[i], kp[i], (i == 2), in_cyc[i] + 1);
                end
            end
        end
        vectors++;
        if (rep_q.size() != 1) begin
            miscompares++;
            $display("FAIL basic_report_count: got %0d required 1", rep_q.size());
        end else begin
            vectors++;
            if (rep_q[0].len !== 16'd20 || rep_q[0].err !== 1'b0 || rep_q[0].c != in_cyc[2] + 1) begin
                miscompares++;
                $display("FAIL basic_report: got len=%0d err=%b @%0d required len=20 err=0 @%0d",
                         rep_q[0].len, rep_q[0].err, rep_q[0].c, in_cyc[2] + 1);
            end
        end
        vectors++;
        if (pkt_count !== 32'd1 || byte_count !== 48'd20 || err_count !== 16'd0) begin
            miscompares++;
            $display("FAIL basic_counters: got %0d/%0d/%0d required 1/20/0", pkt_count, byte_count, err_count);
        end
    endtask

    task automatic test_backpressure();
        clear_logs();
        m_axis_tready = 1'b1;
        fork
            begin
                for (int i = 0; i < 12; i++) send_beat(64'h1000 + 64'(i), 8'hFF, (i % 4) == 3);
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                m_axis_tready = 1'b0;
                @(posedge clk);
                @(negedge clk);
                vectors++;
                if (s_axis_tready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL bp_tready_low: got %b required 0", s_axis_tready);
                end
                repeat (4) @(posedge clk);
                #1;
                m_axis_tready = 1'b1;
            end
        join
        repeat (6) @(posedge clk);
        #1;
        vectors++;
        if (out_q.size() != 12) begin
            miscompares++;
            $display("FAIL bp_beat_count: got %0d required 12", out_q.size());
        end else begin
            for (int i = 0; i < 12; i++) begin
                vectors++;
                if (out_q[i].d !== 64'h1000 + 64'(i) || out_q[i].l !== ((i % 4) == 3)) begin
                    miscompares++;
                    $display("FAIL bp_order%0d: got %h/%b required %h/%b",
                             i, out_q[i].d, out_q[i].l, 64'h1000 + 64'(i), ((i % 4) == 3));
                end
            end
        end
        vectors++;
        if (rep_q.size() != 3) begin
            miscompares++;
            $display("FAIL bp_reports: got %0d required 3", rep_q.size());
        end
        vectors++;
        if (pkt_count !== 32'd4 || byte_count !== 48'd116 || err_count !== 16'd0) begin
            miscompares++;
            $display("FAIL bp_counters: got %0d/%0d/%0d required 4/116/0", pkt_count, byte_count, err_count);
        end
    endtask

    task automatic test_errors();
        clear_logs();
        // middle beat short: 8+4+8 = 20 bytes
        send_beat(64'h1, 8'hFF, 1'b0);
        send_beat(64'h2, 8'h0F, 1'b0);
        send_beat(64'h3, 8'hFF, 1'b1);
        // non-contiguous final mask: popcount(0x05) = 2 bytes
        send_beat(64'h4, 8'h05, 1'b1);
        // empty final mask
        send_beat(64'h5, 8'h00, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (rep_q.size() != 3) begin
            miscompares++;
            $display("FAIL err_reports: got %0d required 3", rep_q.size());
        end else begin
            vectors++;
            if (rep_q[0].len !== 16'd20 || rep_q[0].err !== 1'b1) begin
                miscompares++;
                $display("FAIL err_mid_keep: got len=%0d err=%b required len=20 err=1", rep_q[0].len, rep_q[0].err);
            end
            vectors++;
            if (rep_q[1].len !== 16'd2 || rep_q[1].err !== 1'b1) begin
                miscompares++;
                $display("FAIL err_keep05: got len=%0d err=%b required len=2 err=1", rep_q[1].len, rep_q[1].err);
            end
            vectors++;
            if (rep_q[2].len !== 16'd0 || rep_q[2].err !== 1'b1) begin
                miscompares++;
                $display("FAIL err_keep00: got len=%0d err=%b required len=0 err=1", rep_q[2].len, rep_q[2].err);
            end
        end
        vectors++;
        if (pkt_count !== 32'd7 || byte_count !== 48'd138 || err_count !== 16'd3) begin
            miscompares++;
            $display("FAIL err_counters: got %0d/%0d/%0d required 7/138/3", pkt_count, byte_count, err_count);
        end
    endtask

    task automatic test_length();
        clear_logs();
        send_pkt(9, 8'hFF);
        send_pkt(8, 8'hFF);
        send_pkt(1, 8'h7F);
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (rep_q.size() != 3) begin
            miscompares++;
            $display("FAIL len_reports: got %0d required 3", rep_q.size());
        end else begin
            vectors++;
            if (rep_q[0].len !== 16'd72 || rep_q[0].err !== 1'b1) begin
                miscompares++;
                $display("FAIL len_over: got len=%0d err=%b required len=72 err=1", rep_q[0].len, rep_q[0].err);
            end
            vectors++;
            if (rep_q[1].len !== 16'd64 || rep_q[1].err !== 1'b0) begin
                miscompares++;
                $display("FAIL len_at_max: got len=%0d err=%b required len=64 err=0", rep_q[1].len, rep_q[1].err);
            end
            vectors++;
            if (rep_q[2].len !== 16'd7 || rep_q[2].err !== 1'b0) begin
                miscompares++;
                $display("FAIL len_keep7f: got len=%0d err=%b required len=7 err=0", rep_q[2].len, rep_q[2].err);
            end
        end
        vectors++;
        if (pkt_count !== 32'd10 || byte_count !== 48'd281 || err_count !== 16'd4) begin
            miscompares++;
            $display("FAIL len_counters: got %0d/%0d/%0d required 10/281/4", pkt_count, byte_count, err_count);
        end
    endtask

    task automatic test_stat_clear();
        clear_logs();
        send_beat(64'h77, 8'hFF, 1'b0);
        stat_clear = 1'b1;
        send_beat(64'h78, 8'h03, 1'b1);
        stat_clear = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (pkt_count !== 32'd0 || byte_count !== 48'd0 || err_count !== 16'd0) begin
            miscompares++;
            $display("FAIL clr_counters: got %0d/%0d/%0d required 0/0/0", pkt_count, byte_count, err_count);
        end
        vectors++;
        if (rep_q.size() != 1) begin
            miscompares++;
            $display("FAIL clr_report_count: got %0d required 1", rep_q.size());
        end else begin
            vectors++;
            if (rep_q[0].len !== 16'd10 || rep_q[0].err !== 1'b0) begin
                miscompares++;
                $display("FAIL clr_report: got len=%0d err=%b required len=10 err=0", rep_q[0].len, rep_q[0].err);
            end
        end
    endtask

    task automatic test_reset_abort();
        send_beat(64'h90, 8'hFF, 1'b0);
        send_beat(64'h91, 8'hFF, 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_logs();
        send_beat(64'h92, 8'hFF, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (rep_q.size() != 1) begin
            miscompares++;
            $display("FAIL abort_reports: got %0d required 1", rep_q.size());
        end else begin
            vectors++;
            if (rep_q[0].len !== 16'd8 || rep_q[0].err !== 1'b0) begin
                miscompares++;
                $display("FAIL abort_report: got len=%0d err=%b required len=8 err=0", rep_q[0].len, rep_q[0].err);
            end
        end
        vectors++;
        if (pkt_count !== 32'd1 || byte_count !== 48'd8 || err_count !== 16'd0) begin
            miscompares++;
            $display("FAIL abort_counters: got %0d/%0d/%0d required 1/8/0", pkt_count, byte_count, err_count);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_errors();
        test_length();
        test_stat_clear();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
